// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the DRAM arbiter: FSM states, access op and counter widths.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
  localparam int LAT_W = 3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Bundle of the per-core request lines and the single-port RAM bus around the arbiter.
interface dram_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int N_CORES = 4
);

  logic [N_CORES-1:0]       core_read;
  logic [N_CORES-1:0]       core_write;
  logic [N_CORES*WIDTH-1:0] core_addr;
  logic [N_CORES*WIDTH-1:0] core_wdata;
  logic [N_CORES-1:0]       core_ready;
  logic [WIDTH-1:0]         core_rdata;
  logic                     mem_read;
  logic                     mem_write;
  logic [WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]         mem_wdata;
  logic [WIDTH-1:0]         mem_rdata;

  // master: the arbiter, which masters the RAM and answers the cores.
  modport master (
    input  core_read, core_write, core_addr, core_wdata, mem_rdata,
    output core_ready, core_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  // slave: the surrounding cores and RAM.
  modport slave (
    output core_read, core_write, core_addr, core_wdata, mem_rdata,
    input  core_ready, core_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo N_CORES.
module dram_arbiter_rr_pick
  import dram_arbiter_pkg::*;
#(
  parameter  int N_CORES = 4,
  localparam int GW      = idx_width(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               any_req
);

  always_comb begin
    int idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    // Scan from the farthest candidate back to the nearest so the nearest requester wins.
    for (int off = N_CORES; off >= 1; off--) begin
      idx = int'(last_grant) + off;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (req[idx[GW-1:0]]) begin
        grant   = idx[GW-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port RAM among N_CORES cores,
// one transaction in flight, with a one-cycle completion strobe back to the granted core.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N_CORES = 4,
  parameter int MEM_LAT = 2
) (
  input logic            Clk,
  input logic            Rst,
  dram_arbiter_if.master bus
);

  localparam int GW = idx_width(N_CORES);

  state_t             state, state_nxt;
  op_t                op, op_nxt;
  logic [GW-1:0]      grant, grant_nxt;
  logic [GW-1:0]      last_grant, last_grant_nxt;
  logic [GW-1:0]      pick;
  logic               any_req;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
  logic [N_CORES-1:0] ready, ready_nxt;
  logic [WIDTH-1:0]   rdata, rdata_nxt;
  logic [WIDTH-1:0]   addr, addr_nxt;
  logic [WIDTH-1:0]   wdata, wdata_nxt;
  logic               rd, rd_nxt;
  logic               wr, wr_nxt;

  logic [WIDTH-1:0]   addr_slice  [N_CORES];
  logic [WIDTH-1:0]   wdata_slice [N_CORES];

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      addr_slice[i]  = bus.core_addr[i*WIDTH +: WIDTH];
      wdata_slice[i] = bus.core_wdata[i*WIDTH +: WIDTH];
    end
  end

  dram_arbiter_rr_pick #(
    .N_CORES (N_CORES)
  ) u_pick (
    .req        (bus.core_read | bus.core_write),
    .last_grant (last_grant),
    .grant      (pick),
    .any_req    (any_req)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_IDLE;
      op         <= OP_READ;
      grant      <= '0;
      last_grant <= GW'(N_CORES - 1);
      lat_cnt    <= '0;
      ready      <= '0;
      rdata      <= '0;
      addr       <= '0;
      wdata      <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
    end else begin
      state      <= state_nxt;
      op         <= op_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      lat_cnt    <= lat_cnt_nxt;
      ready      <= ready_nxt;
      rdata      <= rdata_nxt;
      addr       <= addr_nxt;
      wdata      <= wdata_nxt;
      rd         <= rd_nxt;
      wr         <= wr_nxt;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nxt      = state;
    op_nxt         = op;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    lat_cnt_nxt    = lat_cnt;
    ready_nxt      = '0;
    rdata_nxt      = rdata;
    addr_nxt       = addr;
    wdata_nxt      = wdata;
    rd_nxt         = rd;
    wr_nxt         = wr;

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          // A core raising both read and write is served as a write.
          grant_nxt   = pick;
          op_nxt      = bus.core_write[pick] ? OP_WRITE : OP_READ;
          addr_nxt    = addr_slice[pick];
          wdata_nxt   = wdata_slice[pick];
          rd_nxt      = ~bus.core_write[pick];
          wr_nxt      = bus.core_write[pick];
          lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
          state_nxt   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (lat_cnt == '0) begin
          rd_nxt           = 1'b0;
          wr_nxt           = 1'b0;
          ready_nxt[grant] = 1'b1;
          if (op == OP_READ) rdata_nxt = bus.mem_rdata;
          state_nxt        = ST_DONE;
        end else begin
          lat_cnt_nxt = lat_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        last_grant_nxt = grant;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.core_ready = ready;
  assign bus.core_rdata = rdata;
  assign bus.mem_read   = rd;
  assign bus.mem_write  = wr;
  assign bus.mem_addr   = addr;
  assign bus.mem_wdata  = wdata;

endmodule
